hwpe_stream_tcdm_fifo_credit: RTL and testbench
===============================================

# hwpe_stream_tcdm_fifo_credit

Parametrised, credit-managed decoupling FIFO for HWPE-MemDecoupled (TCDM) traffic, sitting between a streamer's TCDM port and the cluster interconnect. Requests are buffered in a request FIFO. Responses are buffered in a response FIFO whose space is reserved per issued request through a credit counter, so every granted request is guaranteed a slot. It adds configurable widths and depths, occupancy/credit visibility, safe flush with in-flight response draining, and protocol-error detection.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width BE_WIDTH = DATA_WIDTH/8. Must be a multiple of 8.
- REQ_DEPTH, 4, request FIFO entries; power of 2, ≥2.
- RESP_DEPTH, 8, response FIFO entries and credit pool size; power of 2, ≥2.

Ports:
- clk_i  in  1  clock. Single clock domain. Reset is synchronous and active-low.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  synchronous flush.
- slv_req_i / slv_gnt_o  in/out  1  slave-side request handshake.
- slv_add_i  in  ADDR_WIDTH  slave-side address.
- slv_wen_i  in  1  slave-side write enable; 1 = read.
- slv_be_i  in  BE_WIDTH  slave-side byte enables.
- slv_data_i  in  DATA_WIDTH  slave-side write data.
- slv_r_data_o / slv_r_valid_o  out  DATA_WIDTH/1  response to consumer.
- ready_i  in  1  consumer backpressure on responses.
- mst_req_o / mst_gnt_i  out/in  1  master-side request handshake.
- mst_add_o, mst_wen_o, mst_be_o, mst_data_o  out  as slave-side counterparts.
- mst_r_data_i / mst_r_valid_i  in  DATA_WIDTH/1  response from interconnect.
- credit_o  out  $clog2(RESP_DEPTH+1)  free response credits.
- req_count_o / resp_count_o  out  $clog2(depth+1)  FIFO occupancies.
- empty_o  out  1  both FIFOs empty, outstanding = 0, drop = 0.
- err_o  out  1  sticky: an unexpected mst_r_valid_i was received.

## Operation
- Every granted master request (read or write) returns exactly one mst_r_valid_i, in order, at least 1 cycle after the grant.
- Request path: push on slv_req_i & slv_gnt_o, with slv_gnt_o = !req_full. Master fields are driven from the FIFO head. mst_req_o = !req_empty & (credit_o != 0). Pop on mst_req_o & mst_gnt_i.
- Counters: outstanding (granted, response not yet received) and drop (responses to discard).
- Credit: credit_o = RESP_DEPTH − outstanding − drop − resp_count_o.
- Response path: mst_r_valid_i with drop == 0 pushes into the response FIFO; the slot is guaranteed by the credit rule. Outstanding decrements.
  - If drop != 0, the response is discarded and drop decrements.
  - If outstanding == drop == 0, the response is discarded and err_o is set.
- slv_r_valid_o = !resp_empty & ready_i; slv_r_data_o = head. Pop on slv_r_valid_o.
- Simultaneous grant and response: outstanding unchanged. Simultaneous push and pop on a FIFO: occupancy unchanged. This is legal when full for the response FIFO only if a pop occurs.
- clear_i flushes both FIFOs and clears err_o.
  - drop ← drop + outstanding − (1 if a response arrives that cycle); outstanding ← 0.
  - mst_req_o and slv_gnt_o are forced 0 during the clear cycle.
- Pointers wrap modulo depth. Counters never over- or underflow under legal stimulus.

## Timing
- Reset values: slv_gnt_o=1 once out of reset (0 while rst_ni=0); mst_req_o=0; slv_r_valid_o=0; credit_o=RESP_DEPTH; counts 0; empty_o=1; err_o=0; data outputs 0.
- Request latency: a slave grant at cycle N gives mst_req_o at N+1 at the earliest. There is no combinational slave→master path.
- Response latency: mst_r_valid_i at N gives slv_r_valid_o at N+1 at the earliest (default build).
- mst_req_o depends only on registered state, never on mst_gnt_i.
- Reset mid-operation: all state returns to reset values; in-flight responses are not tracked.

## Configuration
- HWPE_STREAM_TCDM_FIFO_RESP_BYPASS_EN defined: if the response FIFO is empty, drop == 0 and ready_i=1, mst_r_valid_i/mst_r_data_i go directly to slv_r_valid_o/slv_r_data_o in the same cycle. No push occurs and the credit is returned immediately.
- Not defined: all responses pass through the FIFO, giving 1-cycle minimum latency and no combinational r_valid→r_valid path.

## Test plan
- Single read, gnt=1, response 1 cycle later, ready_i=1 → slv_r_valid_o one cycle after mst_r_valid_i with matching data (0 cycles with BYPASS_EN). credit_o goes 8→7→8.
- 12 back-to-back reads, ready_i=0, immediate responses (RESP_DEPTH=8) → exactly 8 master grants, then mst_req_o=0 with credit_o=0. Raising ready_i drains and resumes issue, with in-order data.
- Slave bursts 6 requests, mst_gnt_i=0 (REQ_DEPTH=4) → slv_gnt_o falls after 4 accepts. Releasing gnt pops in order with correct add/be/wen/data.
- 3 requests outstanding, clear_i pulse, then 3 responses → all dropped, slv_r_valid_o stays 0, credit_o returns to 8, empty_o=1, err_o=0.
- mst_r_valid_i with nothing outstanding → err_o=1 sticky until clear_i. FIFOs unchanged.
- rst_ni low mid-burst for 1 cycle → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/hwpe_stream_tcdm_fifo_credit_if.sv
// TCDM request/response bundle with master and slave views.
// Used on both sides of hwpe_stream_tcdm_fifo_credit.
interface hwpe_stream_tcdm_fifo_credit_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic                  req;
   logic                  gnt;
   logic [ADDR_WIDTH-1:0] add;
   logic                  wen;
   logic [BE_WIDTH-1:0]   be;
   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );
endinterface

// File: rtl/hwpe_stream_tcdm_fifo_credit.sv
// Credit-managed TCDM decoupling FIFO: request queue plus credit-reserved response queue.
// Define HWPE_STREAM_TCDM_FIFO_RESP_BYPASS_EN for a same-cycle response bypass.
module hwpe_stream_tcdm_fifo_credit #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REQ_DEPTH  = 4,
   parameter int unsigned RESP_DEPTH = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            clear_i,
   input  logic                            ready_i,
   hwpe_stream_tcdm_fifo_credit_if.slave   slv,
   hwpe_stream_tcdm_fifo_credit_if.master  mst,
   output logic [$clog2(RESP_DEPTH+1)-1:0] credit_o,
   output logic [$clog2(REQ_DEPTH+1)-1:0]  req_count_o,
   output logic [$clog2(RESP_DEPTH+1)-1:0] resp_count_o,
   output logic                            empty_o,
   output logic                            err_o
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned RQ_AW    = $clog2(REQ_DEPTH);
   localparam int unsigned RQ_CW    = $clog2(REQ_DEPTH + 1);
   localparam int unsigned RS_AW    = $clog2(RESP_DEPTH);
   localparam int unsigned RS_CW    = $clog2(RESP_DEPTH + 1);

   localparam logic [RQ_CW-1:0] RQ_FULL = RQ_CW'(REQ_DEPTH);
   localparam logic [RS_CW-1:0] RS_FULL = RS_CW'(RESP_DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] add;
      logic                  wen;
      logic [BE_WIDTH-1:0]   be;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   req_t                  req_mem [REQ_DEPTH];
   logic [RQ_AW-1:0]      req_wptr;
   logic [RQ_AW-1:0]      req_rptr;
   logic [RQ_CW-1:0]      req_cnt;

   logic [DATA_WIDTH-1:0] resp_mem [RESP_DEPTH];
   logic [RS_AW-1:0]      resp_wptr;
   logic [RS_AW-1:0]      resp_rptr;
   logic [RS_CW-1:0]      resp_cnt;

   logic [RS_CW-1:0]      outstanding;
   logic [RS_CW-1:0]      drop;
   logic                  err;

   logic                  req_empty;
   logic                  req_full;
   logic                  resp_empty;
   logic                  req_push;
   logic                  req_pop;
   logic                  resp_push;
   logic                  resp_pop;
   logic                  rsp_in;
   logic                  rsp_drop;
   logic                  rsp_take;
   logic                  rsp_err;
   logic                  rsp_late;
   logic                  bypass;
   logic [RS_CW-1:0]      credit;
   req_t                  head;

   always_comb begin
      req_empty  = (req_cnt == '0);
      req_full   = (req_cnt == RQ_FULL);
      resp_empty = (resp_cnt == '0);
      credit     = RS_FULL - outstanding - drop - resp_cnt;
      head       = req_mem[req_rptr];
   end

   // Request side: grant on space, issue only when a response slot is reserved.
   always_comb begin
      slv.gnt  = rst_ni & ~clear_i & ~req_full;
      mst.req  = ~clear_i & ~req_empty & (credit != '0);
      mst.add  = req_empty ? '0 : head.add;
      mst.wen  = req_empty ? 1'b0 : head.wen;
      mst.be   = req_empty ? '0 : head.be;
      mst.data = req_empty ? '0 : head.data;
      req_push = slv.req & slv.gnt;
      req_pop  = mst.req & mst.gnt;
   end

   always_comb begin
      rsp_in   = mst.r_valid;
      rsp_drop = rsp_in & (drop != '0);
      rsp_take = rsp_in & (drop == '0) & (outstanding != '0);
      rsp_err  = rsp_in & (drop == '0) & (outstanding == '0);
      rsp_late = rsp_in & ((drop != '0) | (outstanding != '0));
`ifdef HWPE_STREAM_TCDM_FIFO_RESP_BYPASS_EN
      bypass   = rsp_take & resp_empty & ready_i & ~clear_i;
`else
      bypass   = 1'b0;
`endif
      resp_push   = rsp_take & ~bypass & ~clear_i;
      resp_pop    = ~resp_empty & ready_i;
      slv.r_valid = resp_pop | bypass;
      if (bypass)
         slv.r_data = mst.r_data;
      else if (resp_empty)
         slv.r_data = '0;
      else
         slv.r_data = resp_mem[resp_rptr];
   end

   always_ff @(posedge clk_i) begin
      if (req_push)
         req_mem[req_wptr] <= '{
            add:  slv.add,
            wen:  slv.wen,
            be:   slv.be,
            data: slv.data
         };
   end

   always_ff @(posedge clk_i) begin
      if (resp_push)
         resp_mem[resp_wptr] <= mst.r_data;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         req_wptr    <= '0;
         req_rptr    <= '0;
         req_cnt     <= '0;
         resp_wptr   <= '0;
         resp_rptr   <= '0;
         resp_cnt    <= '0;
         outstanding <= '0;
         drop        <= '0;
         err         <= 1'b0;
      end else if (clear_i) begin
         req_wptr    <= '0;
         req_rptr    <= '0;
         req_cnt     <= '0;
         resp_wptr   <= '0;
         resp_rptr   <= '0;
         resp_cnt    <= '0;
         // Everything still in flight will come back and must be discarded.
         outstanding <= '0;
         drop        <= drop + outstanding - RS_CW'(rsp_late);
         err         <= 1'b0;
      end else begin
         if (req_push)
            req_wptr <= req_wptr + RQ_AW'(1);
         if (req_pop)
            req_rptr <= req_rptr + RQ_AW'(1);
         req_cnt <= req_cnt + RQ_CW'(req_push) - RQ_CW'(req_pop);
         if (resp_push)
            resp_wptr <= resp_wptr + RS_AW'(1);
         if (resp_pop)
            resp_rptr <= resp_rptr + RS_AW'(1);
         resp_cnt    <= resp_cnt + RS_CW'(resp_push) - RS_CW'(resp_pop);
         outstanding <= outstanding + RS_CW'(req_pop) - RS_CW'(rsp_take);
         drop        <= drop - RS_CW'(rsp_drop);
         if (rsp_err)
            err <= 1'b1;
      end
   end

   assign credit_o     = credit;
   assign req_count_o  = req_cnt;
   assign resp_count_o = resp_cnt;
   assign err_o        = err;
   assign empty_o      = req_empty & resp_empty &
                         (outstanding == '0) & (drop == '0);

endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_credit.sv
// Scoreboard bench for hwpe_stream_tcdm_fifo_credit with a simple interconnect model.
// Expected requests/responses are queued at issue time and checked by monitors.
`timescale 1ns/1ps
module tb_hwpe_stream_tcdm_fifo_credit;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned BW  = 4;
   localparam int unsigned RQD = 4;
   localparam int unsigned RSD = 8;
`ifdef HWPE_STREAM_TCDM_FIFO_RESP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0] add;
      logic          wen;
      logic [BW-1:0] be;
      logic [DW-1:0] data;
   } rq_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       ready = 1'b1;
   logic [3:0] credit;
   logic [2:0] req_cnt;
   logic [3:0] resp_cnt;
   logic       empty;
   logic       err;

   rq_t           exp_req[$];
   logic [DW-1:0] exp_rsp[$];
   logic [DW-1:0] pend[$];
   int            checks = 0;
   int            errors = 0;
   int            grants = 0;
   bit            rsp_en = 1'b0;

   hwpe_stream_tcdm_fifo_credit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
   hwpe_stream_tcdm_fifo_credit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

   hwpe_stream_tcdm_fifo_credit #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .REQ_DEPTH (RQD),
      .RESP_DEPTH(RSD)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .ready_i     (ready),
      .slv         (s_if),
      .mst         (m_if),
      .credit_o    (credit),
      .req_count_o (req_cnt),
      .resp_count_o(resp_cnt),
      .empty_o     (empty),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rmodel(input logic [AW-1:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h0101};
   endfunction

   task automatic chk(input string name, input logic [95:0] act,
                      input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      repeat (n) cyc();
   endtask

   task automatic send(input logic [AW-1:0] a, input logic w,
                       input logic [BW-1:0] b, input logic [DW-1:0] d,
                       input bit want);
      int n = 0;
      s_if.req  = 1'b1;
      s_if.add  = a;
      s_if.wen  = w;
      s_if.be   = b;
      s_if.data = d;
      @(negedge clk);
      while (s_if.gnt !== 1'b1 && n < 64) begin
         cyc();
         @(negedge clk);
         n++;
      end
      if (s_if.gnt === 1'b1) begin
         exp_req.push_back('{add: a, wen: w, be: b, data: d});
         if (want)
            exp_rsp.push_back(rmodel(a));
      end else begin
         checks++;
         errors++;
         $display("FAIL send_timeout add=%0h actual_gnt=%b required=1", a, s_if.gnt);
      end
      cyc();
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_rsp.size() != 0 || pend.size() != 0 || empty !== 1'b1) && n < 200) begin
         cyc();
         n++;
      end
      @(negedge clk);
      chk({name, "_rsp_left"}, 96'(exp_rsp.size()), 96'(0));
      chk({name, "_empty"}, 96'(empty), 96'(1));
   endtask

   // Interconnect model: checks issued requests, answers 1 cycle after grant.
   initial begin
      logic          fire;
      logic [AW-1:0] fadd;
      rq_t           got;
      rq_t           want;
      m_if.r_valid = 1'b0;
      m_if.r_data  = '0;
      forever begin
         @(negedge clk);
         fire = (m_if.req === 1'b1) && (m_if.gnt === 1'b1);
         fadd = m_if.add;
         if (fire) begin
            grants++;
            got = '{add: m_if.add, wen: m_if.wen, be: m_if.be, data: m_if.data};
            if (exp_req.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mst_req_unexpected actual=%0h required=none", got);
            end else begin
               want = exp_req.pop_front();
               chk("mst_fields", 96'(got), 96'(want));
            end
         end
         @(posedge clk);
         #1;
         if (fire)
            pend.push_back(rmodel(fadd));
         if (rsp_en && pend.size() != 0) begin
            m_if.r_valid = 1'b1;
            m_if.r_data  = pend.pop_front();
         end else begin
            m_if.r_valid = 1'b0;
            m_if.r_data  = '0;
         end
      end
   end

   // Consumer-side monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (s_if.r_valid === 1'b1) begin
            if (exp_rsp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected actual=%0h required=none", s_if.r_data);
            end else begin
               chk("rsp_data", 96'(s_if.r_data), 96'(exp_rsp.pop_front()));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int g0;
      s_if.req  = 1'b0;
      s_if.add  = '0;
      s_if.wen  = 1'b0;
      s_if.be   = '0;
      s_if.data = '0;
      m_if.gnt  = 1'b0;

      // Reset
      cyc();
      @(negedge clk);
      chk("gnt_in_reset", 96'(s_if.gnt), 96'(0));
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_gnt", 96'(s_if.gnt), 96'(1));
      chk("rst_mst_req", 96'(m_if.req), 96'(0));
      chk("rst_r_valid", 96'(s_if.r_valid), 96'(0));
      chk("rst_credit", 96'(credit), 96'(RSD));
      chk("rst_req_cnt", 96'(req_cnt), 96'(0));
      chk("rst_resp_cnt", 96'(resp_cnt), 96'(0));
      chk("rst_empty", 96'(empty), 96'(1));
      chk("rst_err", 96'(err), 96'(0));
      chk("rst_r_data", 96'(s_if.r_data), 96'(0));
      chk("rst_mst_add", 96'(m_if.add), 96'(0));

      // Single read, immediate response
      cyc();
      m_if.gnt = 1'b1;
      rsp_en   = 1'b1;
      send(32'h0000_1000, 1'b1, 4'hF, 32'h0, 1'b1);
      s_if.req = 1'b0;
      @(negedge clk);
      chk("t1_mst_req", 96'(m_if.req), 96'(1));
      chk("t1_credit_pre", 96'(credit), 96'(8));
      cyc();
      @(negedge clk);
      chk("t1_credit_out", 96'(credit), 96'(7));
      chk("t1_rv_same", 96'(s_if.r_valid), 96'(BYP ? 1 : 0));
      cyc();
      @(negedge clk);
      chk("t1_rv_next", 96'(s_if.r_valid), 96'(BYP ? 0 : 1));
      chk("t1_credit_rsp", 96'(credit), 96'(BYP ? 8 : 7));
      cyc();
      @(negedge clk);
      chk("t1_credit_end", 96'(credit), 96'(8));
      chk("t1_empty", 96'(empty), 96'(1));

      // 12 reads with consumer stalled: credit limits issue to 8
      cyc();
      ready = 1'b0;
      g0 = grants;
      for (int i = 0; i < 12; i++)
         send(32'h0000_2000 + 32'(i * 4), 1'b1, 4'hF, 32'h0, 1'b1);
      s_if.req = 1'b0;
      wait_n(6);
      @(negedge clk);
      chk("t2_grants", 96'(grants - g0), 96'(8));
      chk("t2_mst_req", 96'(m_if.req), 96'(0));
      chk("t2_credit", 96'(credit), 96'(0));
      chk("t2_resp_cnt", 96'(resp_cnt), 96'(8));
      chk("t2_req_cnt", 96'(req_cnt), 96'(4));
      cyc();
      ready = 1'b1;
      drain("t2");
      chk("t2_grants_all", 96'(grants - g0), 96'(12));

      // Request FIFO fills while master stalls
      cyc();
      m_if.gnt = 1'b0;
      g0 = grants;
      for (int i = 0; i < 4; i++)
         send(32'h0000_3000 + 32'(i * 4), 1'b0, 4'(1 << i),
              32'hD000_0000 + 32'(i), 1'b1);
      s_if.add  = 32'h0000_3010;
      s_if.wen  = 1'b0;
      s_if.be   = 4'hC;
      s_if.data = 32'hD000_0004;
      @(negedge clk);
      chk("t3_gnt_full", 96'(s_if.gnt), 96'(0));
      chk("t3_req_cnt", 96'(req_cnt), 96'(4));
      cyc();
      m_if.gnt = 1'b1;
      send(32'h0000_3010, 1'b0, 4'hC, 32'hD000_0004, 1'b1);
      send(32'h0000_3014, 1'b1, 4'h3, 32'hD000_0005, 1'b1);
      s_if.req = 1'b0;
      drain("t3");
      chk("t3_grants", 96'(grants - g0), 96'(6));

      // Clear with 3 responses outstanding and one request queued
      cyc();
      rsp_en = 1'b0;
      for (int i = 0; i < 3; i++)
         send(32'h0000_4000 + 32'(i * 4), 1'b1, 4'hF, 32'h0, 1'b0);
      s_if.req = 1'b0;
      wait_n(4);
      @(negedge clk);
      chk("t4_credit_out", 96'(credit), 96'(5));
      cyc();
      m_if.gnt = 1'b0;
      send(32'h0000_4010, 1'b1, 4'hF, 32'h0, 1'b0);
      s_if.req = 1'b0;
      s_if.add = 32'h0000_4014;
      s_if.req = 1'b1;
      m_if.gnt = 1'b1;
      clear    = 1'b1;
      @(negedge clk);
      chk("t4_mst_req_clear", 96'(m_if.req), 96'(0));
      chk("t4_gnt_clear", 96'(s_if.gnt), 96'(0));
      cyc();
      clear    = 1'b0;
      s_if.req = 1'b0;
      exp_req.delete();
      @(negedge clk);
      chk("t4_req_cnt", 96'(req_cnt), 96'(0));
      chk("t4_credit_drop", 96'(credit), 96'(5));
      chk("t4_not_empty", 96'(empty), 96'(0));
      cyc();
      rsp_en = 1'b1;
      wait_n(6);
      @(negedge clk);
      chk("t4_credit_end", 96'(credit), 96'(8));
      chk("t4_empty", 96'(empty), 96'(1));
      chk("t4_err", 96'(err), 96'(0));
      chk("t4_resp_cnt", 96'(resp_cnt), 96'(0));

      // Unexpected response sets sticky error
      cyc();
      pend.push_back(32'hDEAD_BEEF);
      wait_n(3);
      @(negedge clk);
      chk("t5_err", 96'(err), 96'(1));
      chk("t5_resp_cnt", 96'(resp_cnt), 96'(0));
      chk("t5_credit", 96'(credit), 96'(8));
      chk("t5_empty", 96'(empty), 96'(1));
      wait_n(3);
      @(negedge clk);
      chk("t5_err_sticky", 96'(err), 96'(1));
      cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      @(negedge clk);
      chk("t5_err_clr", 96'(err), 96'(0));

      // Reset in the middle of traffic
      cyc();
      rsp_en = 1'b0;
      send(32'h0000_5000, 1'b1, 4'hF, 32'h0, 1'b0);
      send(32'h0000_5004, 1'b1, 4'hF, 32'h0, 1'b0);
      s_if.req = 1'b0;
      wait_n(3);
      m_if.gnt = 1'b0;
      send(32'h0000_5008, 1'b1, 4'hF, 32'h0, 1'b0);
      send(32'h0000_500C, 1'b1, 4'hF, 32'h0, 1'b0);
      s_if.add = 32'h0000_5010;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("t6_gnt_in_reset", 96'(s_if.gnt), 96'(0));
      cyc();
      rst_n    = 1'b1;
      s_if.req = 1'b0;
      pend.delete();
      exp_req.delete();
      @(negedge clk);
      chk("t6_gnt", 96'(s_if.gnt), 96'(1));
      chk("t6_mst_req", 96'(m_if.req), 96'(0));
      chk("t6_r_valid", 96'(s_if.r_valid), 96'(0));
      chk("t6_credit", 96'(credit), 96'(RSD));
      chk("t6_req_cnt", 96'(req_cnt), 96'(0));
      chk("t6_resp_cnt", 96'(resp_cnt), 96'(0));
      chk("t6_empty", 96'(empty), 96'(1));
      chk("t6_err", 96'(err), 96'(0));

      cyc();
      rsp_en = 1'b1;
      wait_n(3);
      @(negedge clk);
      chk("end_rsp_left", 96'(exp_rsp.size()), 96'(0));
      chk("end_err", 96'(err), 96'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
